// File: rtl/seq_1101_tx_pkg.sv
// Shared definitions for the 1101-sync serial link.
// Holds the sync pattern, the frame state codes and a helper that sizes the
// single cycle counter used by the transmitter. The receiver side imports the
// same package so pattern and framing cannot drift apart.
package seq_1101_tx_pkg;

    // Sync pattern, transmitted MSB first.
    localparam int                SYNC_W = 4;
    localparam logic [SYNC_W-1:0] SYNC   = 4'b1101;

    // Frame states; the encoding is shared with the receiver.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_t;

    // Counter width: clog2 of the longest phase (at least 1), plus one bit.
    function automatic int cnt_width(input int data_w, input int gap);
        int m;
        m = SYNC_W;
        if (data_w > m) m = data_w;
        if (gap > m)    m = gap;
        if (m < 1)      m = 1;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/seq_1101_tx_if.sv
// Parallel-side handshake and serial output of the 1101 framed transmitter.
//   start : request to send, honoured only while ready=1
//   data  : payload word, sampled on the accepting edge
//   ready : transmitter idle
//   busy  : frame in progress (= ~ready)
//   out   : serial line
//   done  : one-cycle pulse after the last frame bit
// master = producer / line observer, slave = transmitter.
interface seq_1101_tx_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              busy;
    logic              out;
    logic              done;

    modport master (
        output start,
        output data,
        input  ready,
        input  busy,
        input  out,
        input  done
    );

    modport slave (
        input  start,
        input  data,
        output ready,
        output busy,
        output out,
        output done
    );
endinterface

// File: rtl/seq_1101_tx_piso_shift.sv
// Parallel-load, MSB-first shift register for the frame payload.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   load       : capture din (has priority over shift)
//   shift      : shift left by one, zero fill
//   din        : parallel payload
//   msb_next   : MSB the register will hold after this edge; lets the
//                transmitter register the serial bit without an extra cycle
module seq_1101_tx_piso_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb_next
);

    logic [DATA_W-1:0] shreg_reg;
    logic [DATA_W-1:0] shreg_next;
    logic [DATA_W-1:0] shifted;

    // Left-shift network; written per bit so DATA_W=1 needs no special case.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_shift
        if (gi == 0) begin : g_lsb
            assign shifted[gi] = 1'b0;
        end else begin : g_up
            assign shifted[gi] = shreg_reg[gi-1];
        end
    end

    always_comb begin
        shreg_next = shreg_reg;
        if (load) begin
            shreg_next = din;
        end else if (shift) begin
            shreg_next = shifted;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_reg <= '0;
        end else begin
            shreg_reg <= shreg_next;
        end
    end

    assign msb_next = shreg_next[DATA_W-1];

endmodule

// File: rtl/seq_1101_tx.sv
// Framed serial transmitter for the 1101-sync link.
// On an accepted start it latches the payload and sends, one bit per clock:
// the sync pattern, the payload MSB first, then GAP idle zeros. The cycle
// after the last bit returns to IDLE with done pulsed; a start seen in that
// cycle is accepted, so frames can run back to back.
// Ports:
//   clk   : clock, all state on posedge
//   reset : asynchronous active-high reset, aborts any frame (no done)
//   bus   : slave side of seq_1101_tx_if (start/data in; ready/busy/out/done out)
// All outputs are registers or state decodes; none depends combinationally
// on start or data.
module seq_1101_tx
    import seq_1101_tx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int GAP    = 2
) (
    input  logic         clk,
    input  logic         reset,
    seq_1101_tx_if.slave bus
);

    localparam int CNT_W = cnt_width(DATA_W, GAP);

    // Terminal count of each phase; GAP_LAST is irrelevant when GAP=0.
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    tx_state_t         state_reg;
    tx_state_t         state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic              out_reg;
    logic              out_next;
    logic              done_reg;
    logic              done_next;
    logic              load;
    logic              shift;
    logic              shreg_msb_next;
    logic [SYNC_W-1:0] sync_bits;

    seq_1101_tx_piso_shift #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .din      (bus.data),
        .msb_next (shreg_msb_next)
    );

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) state_next = ST_SYNC;
            end
            ST_SYNC: begin
                if (cnt_reg == SYNC_LAST) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (cnt_reg == DATA_LAST) state_next = (GAP == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (cnt_reg == GAP_LAST) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Counter, shift control and the value the serial register takes next.
    // out is computed from the *next* state/count so that the registered
    // line shows sync bit 0 in the very first cycle after acceptance.
    always_comb begin
        load      = (state_reg == ST_IDLE) && bus.start;
        shift     = (state_reg == ST_DATA);
        cnt_next  = '0;
        out_next  = 1'b0;
        done_next = 1'b0;
        sync_bits = '0;

        // Counter restarts on every state change and rests at 0 in IDLE.
        if ((state_next == state_reg) && (state_reg != ST_IDLE)) begin
            cnt_next = cnt_reg + 1'b1;
        end

        // Selecting sync bit SYNC_W-1-cnt is done as a shift so the index
        // never needs a width-mismatched subtraction.
        sync_bits = SYNC << cnt_next;

        case (state_next)
            ST_SYNC: out_next = sync_bits[SYNC_W-1];
            ST_DATA: out_next = shreg_msb_next;
            default: out_next = 1'b0;
        endcase

        // Pulse exactly when a frame falls back to IDLE.
        done_next = (state_reg != ST_IDLE) && (state_next == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            out_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            out_reg   <= out_next;
            done_reg  <= done_next;
        end
    end

    assign bus.ready = (state_reg == ST_IDLE);
    assign bus.busy  = (state_reg != ST_IDLE);
    assign bus.out   = out_reg;
    assign bus.done  = done_reg;

endmodule
